// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: command opcodes,
// sequencer state type and a coordinate clamp helper.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC = 8'h3C;
  localparam logic [7:0] CMD_MADCTL = 8'h36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_PASET,
    S_RAMWR,
    S_IGNORE,
    S_MADCTL
  } lcd_state_e;

  // Clamp a coordinate to the last valid index (lim = limit-1).
  function automatic logic [15:0] clamp_coord(input logic [15:0] v,
                                              input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/lcd_addr_gen.sv
// Pixel cursor, window advance/wrap, optional mirroring and the two-stage
// framebuffer address pipeline (stage 1: x/y/data/done, stage 2: address).
module lcd_addr_gen
  import lcd_pkg::*;
#(
  parameter int H_RES  = 480,
  parameter int V_RES  = 320,
  parameter int ADDR_W = 18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_pix,
  input  logic [15:0]       i_rgb565,
  input  logic [15:0]       i_sc,
  input  logic [15:0]       i_ec,
  input  logic [15:0]       i_sp,
  input  logic [15:0]       i_ep,
  input  logic              i_mx,
  input  logic              i_my,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_win_done
);

  localparam logic [15:0] X_MAX = 16'(H_RES - 1);
  localparam logic [15:0] Y_MAX = 16'(V_RES - 1);

  logic [15:0]       r_x, r_y;
  logic              r_s1_v, r_s1_done;
  logic [15:0]       r_s1_x, r_s1_y, r_s1_data;
  logic              r_s2_v, r_s2_done;
  logic [ADDR_W-1:0] r_s2_addr;
  logic [15:0]       r_s2_data;

  logic              w_win_ok, w_issue, w_last;
  logic [15:0]       w_x_m, w_y_m;
  logic [ADDR_W-1:0] w_addr;

  assign w_win_ok = (i_sc <= i_ec) && (i_sp <= i_ep);
  assign w_issue  = i_pix && w_win_ok;
  assign w_last   = !(r_x < i_ec) && !(r_y < i_ep);
  assign w_x_m    = i_mx ? (X_MAX - r_x) : r_x;
  assign w_y_m    = i_my ? (Y_MAX - r_y) : r_y;
  assign w_addr   = ADDR_W'(32'(r_s1_y) * 32'(H_RES) + 32'(r_s1_x));

  // Cursor: load on RAMWR, advance on every issued write
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_x <= i_sc;
      r_y <= i_sp;
    end else if (w_issue) begin
      if (r_x < i_ec) begin
        r_x <= r_x + 16'd1;
      end else if (r_y < i_ep) begin
        r_x <= i_sc;
        r_y <= r_y + 16'd1;
      end else begin
        r_x <= i_sc;
        r_y <= i_sp;
      end
    end
  end

  // Stage 1: mirrored coordinates, pixel data and end-of-window flag
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_done <= 1'b0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
      r_s1_data <= '0;
    end else begin
      r_s1_v    <= w_issue;
      r_s1_done <= w_issue && w_last;
      if (w_issue) begin
        r_s1_x    <= w_x_m;
        r_s1_y    <= w_y_m;
        r_s1_data <= i_rgb565;
      end
    end
  end

  // Stage 2: linear address, outputs aligned
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s2_v    <= 1'b0;
      r_s2_done <= 1'b0;
      r_s2_addr <= '0;
      r_s2_data <= '0;
    end else begin
      r_s2_v    <= r_s1_v;
      r_s2_done <= r_s1_done;
      if (r_s1_v) begin
        r_s2_addr <= w_addr;
        r_s2_data <= r_s1_data;
      end
    end
  end

  assign o_wr_en    = r_s2_v;
  assign o_wr_addr  = r_s2_addr;
  assign o_wr_data  = r_s2_data;
  assign o_win_done = r_s2_done;

endmodule

// File: rtl/lcd_cmd_ctrl.sv
// LCD command sequencer: decodes CASET/PASET/RAMWR/RAMWRC, holds the active
// window and drives the framebuffer write port through lcd_addr_gen.
// Optional feature macro: LCD_CMD_CTRL_MADCTL_EN (0x36 MY/MX mirroring).
module lcd_cmd_ctrl
  import lcd_pkg::*;
#(
  parameter int H_RES  = 480,
  parameter int V_RES  = 320,
  parameter int ADDR_W = 18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_command,
  input  logic              i_command_latch,
  input  logic [7:0]        i_param,
  input  logic              i_param_latch,
  input  logic [15:0]       i_rgb565,
  input  logic              i_rgb565_latch,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_win_done
);

  localparam logic [15:0] X_MAX = 16'(H_RES - 1);
  localparam logic [15:0] Y_MAX = 16'(V_RES - 1);

  lcd_state_e  r_state, w_state_nxt;
  logic [2:0]  r_pidx;
  logic [7:0]  r_b0, r_b1, r_b2;
  logic [15:0] r_sc, r_ec, r_sp, r_ep;
  logic        w_pix_accept, w_param_accept, w_cursor_load, w_commit;
  logic [15:0] w_lim, w_start, w_end;
  logic        w_mx, w_my;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: any command re-targets the sequencer
  always_comb begin
    w_state_nxt = r_state;
    if (i_command_latch) begin
      case (i_command)
        CMD_CASET:  w_state_nxt = S_CASET;
        CMD_PASET:  w_state_nxt = S_PASET;
        CMD_RAMWR:  w_state_nxt = S_RAMWR;
        CMD_RAMWRC: w_state_nxt = S_RAMWR;
`ifdef LCD_CMD_CTRL_MADCTL_EN
        CMD_MADCTL: w_state_nxt = S_MADCTL;
`endif
        default:    w_state_nxt = S_IGNORE;
      endcase
    end
  end

  // Strobe qualification: a command suppresses any pixel/param in its cycle
  always_comb begin
    w_pix_accept   = 1'b0;
    w_param_accept = 1'b0;
    w_cursor_load  = 1'b0;
    if (i_command_latch) begin
      w_cursor_load = (i_command == CMD_RAMWR);
    end else begin
      w_pix_accept   = (r_state == S_RAMWR) && i_rgb565_latch;
      w_param_accept = i_param_latch && (r_pidx < 3'd4) &&
                       ((r_state == S_CASET) || (r_state == S_PASET) ||
                        (r_state == S_MADCTL));
    end
  end

  assign w_commit = w_param_accept && (r_pidx == 3'd3) &&
                    ((r_state == S_CASET) || (r_state == S_PASET));
  assign w_lim    = (r_state == S_CASET) ? X_MAX : Y_MAX;
  assign w_start  = clamp_coord({r_b0, r_b1}, w_lim);
  assign w_end    = clamp_coord({r_b2, i_param}, w_lim);

  // Parameter collection and window commit on the 4th byte
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pidx <= '0;
      r_b0   <= '0;
      r_b1   <= '0;
      r_b2   <= '0;
      r_sc   <= '0;
      r_ec   <= X_MAX;
      r_sp   <= '0;
      r_ep   <= Y_MAX;
    end else if (i_command_latch) begin
      r_pidx <= '0;
    end else if (w_param_accept) begin
      r_pidx <= r_pidx + 3'd1;
      case (r_pidx)
        3'd0:    r_b0 <= i_param;
        3'd1:    r_b1 <= i_param;
        3'd2:    r_b2 <= i_param;
        default: ;
      endcase
      if (w_commit) begin
        if (r_state == S_CASET) begin
          r_sc <= w_start;
          r_ec <= w_end;
        end else begin
          r_sp <= w_start;
          r_ep <= w_end;
        end
      end
    end
  end

`ifdef LCD_CMD_CTRL_MADCTL_EN
  logic r_mx, r_my;

  // MADCTL orientation bits, taken from the first parameter only
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mx <= 1'b0;
      r_my <= 1'b0;
    end else if (w_param_accept && (r_state == S_MADCTL) && (r_pidx == 3'd0)) begin
      r_my <= i_param[7];
      r_mx <= i_param[6];
    end
  end

  assign w_mx = r_mx;
  assign w_my = r_my;
`else
  assign w_mx = 1'b0;
  assign w_my = 1'b0;
`endif

  lcd_addr_gen #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_cursor_load),
    .i_pix      (w_pix_accept),
    .i_rgb565   (i_rgb565),
    .i_sc       (r_sc),
    .i_ec       (r_ec),
    .i_sp       (r_sp),
    .i_ep       (r_ep),
    .i_mx       (w_mx),
    .i_my       (w_my),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_win_done (o_win_done)
  );

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// Scoreboard bench for lcd_cmd_ctrl: directed scenarios plus random traffic
// against a window/cursor reference model. Honours LCD_CMD_CTRL_MADCTL_EN.
module tb_lcd_cmd_ctrl;

  localparam int H  = 480;
  localparam int V  = 320;
  localparam int AW = 18;

  localparam int M_IDLE = 0, M_CASET = 1, M_PASET = 2, M_RAMWR = 3,
                 M_IGNORE = 4, M_MADCTL = 5;

  typedef struct {
    int addr;
    int data;
    bit done;
    int due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    cmd = '0, par = '0;
  logic          cmd_v = 1'b0, par_v = 1'b0, pix_v = 1'b0;
  logic [15:0]   pix = '0;
  logic          o_wr_en, o_win_done;
  logic [AW-1:0] o_wr_addr;
  logic [15:0]   o_wr_data;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   seen_q[$];
  exp_t mon_e;

  // reference model
  int m_mode, m_pcnt, m_sc, m_ec, m_sp, m_ep, m_x, m_y;
  bit m_mx, m_my;
  int m_pb[4];

  lcd_cmd_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_command       (cmd),
    .i_command_latch (cmd_v),
    .i_param         (par),
    .i_param_latch   (par_v),
    .i_rgb565        (pix),
    .i_rgb565_latch  (pix_v),
    .o_wr_en         (o_wr_en),
    .o_wr_addr       (o_wr_addr),
    .o_wr_data       (o_wr_data),
    .o_win_done      (o_win_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (o_win_done && !o_wr_en) begin
      checks++; errors++;
      $display("FAIL done_without_write cyc=%0d", cyc);
    end
    if (o_wr_en) begin
      checks++;
      seen_q.push_back(int'(o_wr_addr));
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%h", cyc, o_wr_addr, o_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(o_wr_addr) != mon_e.addr || int'(o_wr_data) != mon_e.data ||
            o_win_done != mon_e.done || cyc != mon_e.due) begin
          errors++;
          $display("FAIL write cyc=%0d got addr=%0d data=%h done=%0b, want addr=%0d data=%h done=%0b cyc=%0d",
                   cyc, o_wr_addr, o_wr_data, o_win_done, mon_e.addr, mon_e.data, mon_e.done, mon_e.due);
        end
      end
    end
  end

  function automatic int clampi(input int v, input int lim);
    return (v > lim - 1) ? lim - 1 : v;
  endfunction

  function automatic void m_reset();
    m_mode = M_IDLE; m_pcnt = 0;
    m_sc = 0; m_ec = H - 1; m_sp = 0; m_ep = V - 1;
    m_x = 0; m_y = 0; m_mx = 0; m_my = 0;
  endfunction

  function automatic void m_cmd(input int c);
    m_pcnt = 0;
    case (c)
      'h2A: m_mode = M_CASET;
      'h2B: m_mode = M_PASET;
      'h2C: begin m_mode = M_RAMWR; m_x = m_sc; m_y = m_sp; end
      'h3C: m_mode = M_RAMWR;
`ifdef LCD_CMD_CTRL_MADCTL_EN
      'h36: m_mode = M_MADCTL;
`endif
      default: m_mode = M_IGNORE;
    endcase
  endfunction

  function automatic void m_param(input int p);
    int s, e, lim;
    if (m_mode == M_MADCTL) begin
      if (m_pcnt == 0) begin m_my = p[7]; m_mx = p[6]; end
      m_pcnt++;
    end else if ((m_mode == M_CASET || m_mode == M_PASET) && m_pcnt < 4) begin
      m_pb[m_pcnt] = p;
      m_pcnt++;
      if (m_pcnt == 4) begin
        lim = (m_mode == M_CASET) ? H : V;
        s = clampi(m_pb[0] * 256 + m_pb[1], lim);
        e = clampi(m_pb[2] * 256 + m_pb[3], lim);
        if (m_mode == M_CASET) begin m_sc = s; m_ec = e; end
        else begin m_sp = s; m_ep = e; end
      end
    end
  endfunction

  function automatic void m_pixel(input int d, input int now);
    exp_t e;
    int ax, ay;
    if (m_mode != M_RAMWR) return;
    if (m_sc > m_ec || m_sp > m_ep) return;
    ax = m_mx ? (H - 1 - m_x) : m_x;
    ay = m_my ? (V - 1 - m_y) : m_y;
    e.addr = (ay * H + ax) % (1 << AW);
    e.data = d;
    e.done = 0;
    e.due  = now + 2;
    if (m_x < m_ec) m_x++;
    else if (m_y < m_ep) begin m_x = m_sc; m_y++; end
    else begin m_x = m_sc; m_y = m_sp; e.done = 1; end
    exp_q.push_back(e);
  endfunction

  task automatic step(input bit cv, input logic [7:0] c, input bit pv, input logic [7:0] p,
                      input bit xv, input logic [15:0] d);
    cmd_v = cv; cmd = c; par_v = pv; par = p; pix_v = xv; pix = d;
    if (cv) m_cmd(int'(c));
    else if (pv) m_param(int'(p));
    else if (xv) m_pixel(int'(d), cyc);
    @(posedge clk); #1;
    cmd_v = 1'b0; par_v = 1'b0; pix_v = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);   step(1, c, 0, 8'h00, 0, 16'h0000); endtask
  task automatic send_par(input logic [7:0] p);   step(0, 8'h00, 1, p, 0, 16'h0000); endtask
  task automatic send_pix(input logic [15:0] d);  step(0, 8'h00, 0, 8'h00, 1, d);    endtask

  task automatic send4(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] e, input logic [7:0] f);
    send_cmd(c); send_par(a); send_par(b); send_par(e); send_par(f);
  endtask

  // writes already visible at the reset drive cycle survive, later ones are lost
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
    m_reset();
    repeat (n) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d writes still outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_seen(input string name, input int want[$]);
    checks++;
    if (seen_q.size() != want.size()) begin
      errors++;
      $display("FAIL %s count got %0d want %0d", name, seen_q.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        checks++;
        if (seen_q[i] != want[i]) begin
          errors++;
          $display("FAIL %s addr[%0d] got %0d want %0d", name, i, seen_q[i], want[i]);
        end
      end
    end
    seen_q.delete();
  endtask

  int q[$];
  int r;
  logic [7:0] rc;

  initial begin
    m_reset();
    do_reset(3);
    @(negedge clk);
    checks += 4;
    if (o_wr_en !== 1'b0)    begin errors++; $display("FAIL rst_wr_en got %b want 0", o_wr_en); end
    if (o_wr_addr !== '0)    begin errors++; $display("FAIL rst_wr_addr got %0d want 0", o_wr_addr); end
    if (o_wr_data !== '0)    begin errors++; $display("FAIL rst_wr_data got %h want 0", o_wr_data); end
    if (o_win_done !== 1'b0) begin errors++; $display("FAIL rst_win_done got %b want 0", o_win_done); end
    @(posedge clk); #1;

    // full screen, three pixels
    seen_q.delete();
    send_cmd(8'h2C);
    send_pix(16'hA1A1); send_pix(16'hB2B2); send_pix(16'hC3C3);
    drain("basic");
    q = '{0, 1, 2}; check_seen("basic", q);

    // 3x2 window with wrap
    send4(8'h2A, 8'd0, 8'd10, 8'd0, 8'd12);
    send4(8'h2B, 8'd0, 8'd5, 8'd0, 8'd6);
    send_cmd(8'h2C);
    for (int i = 0; i < 7; i++) send_pix(16'(i * 16'h0111 + 16'h1000));
    drain("window");
    q = '{2410, 2411, 2412, 2890, 2891, 2892, 2410}; check_seen("window", q);

    // partial CASET keeps the full-screen window
    do_reset(1);
    send_cmd(8'h2A); send_par(8'd0); send_par(8'd10);
    send_cmd(8'h2C);
    send_pix(16'h1234); send_pix(16'h5678);
    drain("partial");
    q = '{0, 1}; check_seen("partial", q);

    // column range beyond the panel clamps to 479
    send4(8'h2A, 8'h01, 8'hF4, 8'h02, 8'h00);
    send_cmd(8'h2C);
    send_pix(16'hBEEF); send_pix(16'hCAFE);
    drain("clamp");
    q = '{479, 959}; check_seen("clamp", q);

    // 2x2 window, command+pixel collision, RAMWRC continues the cursor
    send4(8'h2A, 8'd0, 8'd0, 8'd0, 8'd1);
    send4(8'h2B, 8'd0, 8'd0, 8'd0, 8'd1);
    send_cmd(8'h2C);
    send_pix(16'h0001); send_pix(16'h0002); send_pix(16'h0003);
    step(1, 8'h3C, 0, 8'h00, 1, 16'hDEAD);
    send_pix(16'h0004);
    drain("ramwrc");
    q = '{0, 1, 480, 481}; check_seen("ramwrc", q);

    // invalid window swallows pixels without moving the cursor
    do_reset(1);
    send4(8'h2A, 8'd0, 8'd5, 8'd0, 8'd3);
    send_cmd(8'h2C);
    send_pix(16'h1111); send_pix(16'h2222); send_pix(16'h3333);
    send4(8'h2A, 8'd0, 8'd3, 8'd0, 8'd5);
    send_cmd(8'h3C);
    send_pix(16'h4444);
    drain("invalid");
    q = '{5}; check_seen("invalid", q);

    // reset right after a pixel strobe: nothing may come out
    send_cmd(8'h2C);
    send_pix(16'h7777);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (o_wr_en !== 1'b0) begin errors++; $display("FAIL post_reset_wr_en cycle %0d got %b want 0", i, o_wr_en); end
    end
    @(posedge clk); #1;
    send_pix(16'h9999);       // IDLE: ignored
    send_par(8'h12);          // IDLE: ignored
    send_cmd(8'h2C);
    send_pix(16'h8888); send_pix(16'h8889);
    drain("after_reset");
    q = '{0, 1}; check_seen("after_reset", q);

`ifdef LCD_CMD_CTRL_MADCTL_EN
    send_cmd(8'h36); send_par(8'hC0);
    send_cmd(8'h2C);
    send_pix(16'hF00D);
    drain("madctl");
    q = '{153599}; check_seen("madctl", q);
    send_cmd(8'h36); send_par(8'h00);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 5))
        0: rc = 8'h2A;
        1: rc = 8'h2B;
        2: rc = 8'h2C;
        3: rc = 8'h3C;
        4: rc = 8'h36;
        default: rc = 8'($urandom_range(0, 255));
      endcase
      if (r < 2) do_reset(1);
      else if (r < 14) send_cmd(rc);
      else if (r < 36) begin
        if (m_pcnt % 2 == 0)
          send_par(($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'h00);
        else
          send_par(($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 15)));
      end
      else if (r < 86) send_pix(16'($urandom));
      else if (r < 92) step(1, rc, 0, 8'h00, 1, 16'($urandom));
      else if (r < 96) step(1, rc, 1, 8'($urandom_range(0, 255)), 0, 16'h0000);
      else step(0, 8'h00, 0, 8'h00, 0, 16'h0000);
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_ctrl.md
# lcd_cmd_ctrl

Command sequencer between the LCD receive interface and the framebuffer write port. It decodes the controller command/parameter stream (CASET 0x2A, PASET 0x2B, RAMWR 0x2C, RAMWRC 0x3C) and keeps the active window and the pixel cursor. Each received RGB565 pixel becomes one framebuffer write with a linear address. It runs in the video clock domain, after the receive interface and in front of the framebuffer write side.

## Interface
- H_RES, 480, panel width in pixels
- V_RES, 320, panel height in pixels
- ADDR_W, 18, framebuffer address width; H_RES*V_RES must be ≤ 2^ADDR_W
- i_clk  in  1  video clock; the only clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_command  in  8  command byte
- i_command_latch  in  1  one-cycle strobe, i_command valid
- i_param  in  8  parameter byte
- i_param_latch  in  1  one-cycle strobe, i_param valid
- i_rgb565  in  16  pixel data
- i_rgb565_latch  in  1  one-cycle strobe, i_rgb565 valid
- o_wr_en  out  1  framebuffer write strobe
- o_wr_addr  out  ADDR_W  write address, y*H_RES + x
- o_wr_data  out  16  write pixel
- o_win_done  out  1  pulses together with the write of the window's last pixel

## Operation
- States: IDLE, CASET, PASET, RAMWR, IGNORE.
- Command decode applies from any state on i_command_latch:
  - 0x2A → CASET; 0x2B → PASET.
  - 0x2C → RAMWR, cursor loaded to (SC, SP).
  - 0x3C → RAMWR, cursor kept.
  - Any other command → IGNORE.
  - The parameter byte index is cleared on every command.
- CASET/PASET parameters, in order: start hi, start lo, end hi, end lo.
  - Window registers (SC/EC or SP/EP) commit only on the 4th parameter.
  - A partial sequence leaves the previous window unchanged.
  - Parameters 5 and later are ignored.
- Clamping at commit: end > limit−1 is clamped to limit−1; start > limit−1 is clamped to limit−1.
- A window is invalid if SC > EC or SP > EP. While invalid, pixels are consumed, no write is issued, and the cursor does not move.
- RAMWR pixel handling, on each i_rgb565_latch:
  - Issue a write at cursor (x, y).
  - If x < EC: x+1.
  - Else if y < EP: x=SC, y+1.
  - Else: wrap to (SC, SP) and flag win_done on this write.
- Ignored inputs: i_rgb565_latch outside RAMWR; i_param_latch in RAMWR, IDLE or IGNORE.
- Simultaneous strobes: the command wins. The pixel or parameter in the same cycle is dropped.
- Reset values:
  - State IDLE.
  - Window SC=0, EC=H_RES−1, SP=0, EP=V_RES−1.
  - Cursor (0,0).
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_win_done=0.
- Reset mid-operation: all state and in-flight pipeline writes are discarded; no write is issued after the reset cycle.
- Cursor x/y are 16-bit; the address is computed as y*H_RES + x truncated to ADDR_W. The product must never overflow for in-range values.

## Timing
- Pixel to write latency: 2 cycles.
  - Stage 1 registers x, y, data and done.
  - Stage 2 registers the address y*H_RES + x.
  - o_wr_en, o_wr_addr, o_wr_data and o_win_done are aligned in the same cycle.
- Throughput: one pixel per cycle with back-to-back strobes.
- o_wr_en and o_win_done are single-cycle pulses, one per accepted pixel.
- A window committed in cycle N applies to a RAMWR issued in cycle N+1 or later.

## Configuration
- LCD_CMD_CTRL_MADCTL_EN defined:
  - Command 0x36 takes one parameter: bit7 MY, bit6 MX. The register resets to 0.
  - Stage 1 mirrors the cursor: x' = H_RES−1−x if MX; y' = V_RES−1−y if MY.
  - Latency is unchanged.
- LCD_CMD_CTRL_MADCTL_EN undefined: 0x36 is treated as an unknown command (IGNORE) and no mirroring is done.

## Structure
- Shared package lcd_pkg holds:
  - Command opcode localparams (CMD_CASET, CMD_PASET, CMD_RAMWR, CMD_RAMWRC, CMD_MADCTL).
  - The state enum typedef.
- Sub-module lcd_addr_gen holds:
  - The cursor registers and window advance/wrap logic.
  - Mirroring and the 2-stage address pipeline.
- The top of this block holds the command/parameter FSM and the window registers.

## Test plan
- Reset, then 0x2C and 3 pixels A,B,C → writes at addr 0,1,2 with data A,B,C, each 2 cycles after its strobe.
- CASET 0,10,0,12; PASET 0,5,0,6; RAMWR; 7 pixels → addrs 2410,2411,2412,2890,2891,2892, then 2410 (wrap); o_win_done high on the 6th write.
- CASET with only 2 params, then RAMWR → writes use the previous full-screen window starting at 0.
- CASET 0x01,0xF4,0x02,0x00 (500..512) → SC=EC=479; 2 pixels → addrs 479, 959.
- Command strobe in the same cycle as a pixel strobe → the pixel is dropped, no write. RAMWRC after 3 pixels of a 2×2 window → next write at cursor (SC+1, SP+1).
- Reset asserted one cycle after a pixel strobe → no o_wr_en follows; state is IDLE and the window is full-screen. With MADCTL_EN, 0x36 param 0xC0 then RAMWR 1 pixel → addr 153599.
